// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier.
// Takes WIDTH cycles per operation and holds the last result on product.
// With SIGNED=1 the core multiplies operand magnitudes, then negates the
// result when the operand signs differ.
module seq_multiplier #(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [WIDTH-1:0]      mcand;       // multiplicand magnitude
   logic [WIDTH-1:0]      mplier;      // multiplier; low product bits shift in from the top
   logic [WIDTH-1:0]      acc;         // upper product half
   logic [CW-1:0]         cnt;
   logic                  neg;         // result must be negated (signed mode only)

   logic                  last;
   logic [WIDTH-1:0]      a_mag, b_mag;
   logic [WIDTH:0]        sum;
   logic [WIDTH-1:0]      acc_nxt, mplier_nxt;
   logic [2*WIDTH-1:0]    prod_mag, prod_fin;

   // The step that sees cnt == WIDTH-1 is the final one.
   assign last = (cnt == CW'(WIDTH - 1));

   // State register; reset wins over everything else.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> DONE after WIDTH steps, DONE -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last)  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decode the state register only.
   always_comb begin
      busy = (state == S_RUN);
      done = (state == S_DONE);
   end

   // Operand magnitudes. The most negative value maps to itself, which is
   // its correct unsigned magnitude.
   always_comb begin
      if (SIGNED) begin
         a_mag = a[WIDTH-1] ? -a : a;
         b_mag = b[WIDTH-1] ? -b : b;
      end else begin
         a_mag = a;
         b_mag = b;
      end
   end

   // One shift-add step. The carry is kept and shifted in as the new acc MSB.
   always_comb begin
      sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
      acc_nxt    = sum[WIDTH:1];
      mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
      prod_mag   = {acc_nxt, mplier_nxt};
      prod_fin   = (SIGNED && neg) ? -prod_mag : prod_mag;
   end

   // Datapath: capture on an accepted start, step while running, load the result on the final step.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         neg     <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  acc    <= '0;
                  cnt    <= '0;
                  neg    <= SIGNED ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
               end
            end
            S_RUN: begin
               acc    <= acc_nxt;
               mplier <= mplier_nxt;
               cnt    <= cnt + CW'(1);
               if (last) product <= prod_fin;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier (WIDTH=8).
// Runs an unsigned and a signed instance side by side on the same stimulus.
// Results are compared against plain-arithmetic products.
module tb_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  a, b;
   logic [15:0] prod_u, prod_s;
   logic        busy_u, busy_s, done_u, done_s;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] exp_u, exp_s;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(8), .SIGNED(1'b0)) u_uns (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .product(prod_u), .busy(busy_u), .done(done_u)
   );

   seq_multiplier #(.WIDTH(8), .SIGNED(1'b1)) u_sgn (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .product(prod_s), .busy(busy_s), .done(done_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input bit sgn);
      int p;
      if (sgn) p = int'($signed(x)) * int'($signed(y));
      else     p = int'(x) * int'(y);
      return p[15:0];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One operation. With scramble set, a, b and start are disturbed while the operation is in RUN.
   task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit scramble);
      logic [15:0] nu, ns;
      nu = ref_mul(x, y, 1'b0);
      ns = ref_mul(x, y, 1'b1);
      a = x; b = y; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("busy_u", busy_u, 1);
         chk("busy_s", busy_s, 1);
         chk("done_u_run", done_u, 0);
         chk("hold_u", prod_u, exp_u);
         chk("hold_s", prod_s, exp_s);
         if (scramble) begin
            a = 8'($urandom);
            b = 8'($urandom);
            start = 1'($urandom_range(0, 1));
         end
         tick;
      end
      start = 1'b0;
      exp_u = nu;
      exp_s = ns;
      chk("done_u", done_u, 1);
      chk("done_s", done_s, 1);
      chk("busy_u_done", busy_u, 0);
      chk("prod_u", prod_u, exp_u);
      chk("prod_s", prod_s, exp_s);
      tick;
      chk("idle_done_u", done_u, 0);
      chk("idle_busy_u", busy_u, 0);
      chk("idle_done_s", done_s, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic saw;
      int   m;
      rst = 1'b1; start = 1'b1; a = 8'h5A; b = 8'hC3;
      exp_u = '0; exp_s = '0;
      tick; tick;
      chk("rst_prod_u", prod_u, 0);
      chk("rst_prod_s", prod_s, 0);
      chk("rst_busy", busy_u, 0);
      chk("rst_done", done_u, 0);
      rst = 1'b0; start = 1'b0;
      tick;

      run_op(8'd13, 8'd11, 1'b0);
      chk("vec_13x11", prod_u, 32'h008F);
      run_op(8'hFF, 8'hFF, 1'b0);
      chk("vec_ffxff", prod_u, 32'hFE01);
      run_op(8'h00, 8'hA5, 1'b0);
      chk("vec_0xa5", prod_u, 32'h0000);
      run_op(8'hFD, 8'h05, 1'b0);
      chk("vec_m3x5", prod_s, 32'hFFF1);
      run_op(8'h80, 8'h80, 1'b0);
      chk("vec_80x80", prod_s, 32'h4000);
      run_op(8'h80, 8'h7F, 1'b1);
      chk("vec_80x7f", prod_s, 32'hC080);

      // Reset in the 4th RUN cycle abandons the operation.
      a = 8'hE7; b = 8'h9B; start = 1'b1;
      tick;
      start = 1'b0;
      tick; tick; tick;
      chk("pre_rst_busy", busy_u, 1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      exp_u = '0; exp_s = '0;
      chk("mid_rst_busy", busy_u, 0);
      chk("mid_rst_done", done_u, 0);
      chk("mid_rst_prod_u", prod_u, 0);
      chk("mid_rst_prod_s", prod_s, 0);
      saw = 1'b0;
      repeat (10) begin
         tick;
         if (done_u || done_s || busy_u) saw = 1'b1;
      end
      chk("no_done_after_rst", saw, 0);
      chk("prod_after_rst", prod_u, 0);

      // Start held high: a new operation every 10 cycles, with one IDLE cycle between them.
      a = 8'd200; b = 8'hF6; start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         tick;
         m = c % 10;
         chk("held_done", done_u, (m == 9) ? 1 : 0);
         chk("held_busy", busy_u, (m >= 1 && m <= 8) ? 1 : 0);
         if (m == 9) begin
            chk("held_prod_u", prod_u, ref_mul(8'd200, 8'hF6, 1'b0));
            chk("held_prod_s", prod_s, ref_mul(8'd200, 8'hF6, 1'b1));
         end
      end
      start = 1'b0;
      exp_u = ref_mul(8'd200, 8'hF6, 1'b0);
      exp_s = ref_mul(8'd200, 8'hF6, 1'b1);
      tick;
      chk("held_end_idle", busy_u, 0);

      for (int n = 0; n < 20; n++) begin
         run_op(8'($urandom), 8'($urandom), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
